// File: rtl/conv_mac_pkg.sv
// Shared constants, types and FSM encoding for the convolution multiply-accumulate stage.
package conv_mac_pkg;

  localparam int unsigned LEN   = 8;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(LEN);

  typedef logic [WIDTH-1:0]     data_t;
  typedef logic [LEN*WIDTH-1:0] data_vector;
  typedef logic [ACC_W-1:0]     acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

endpackage

// File: rtl/conv_mult_acc.sv
// One unsigned WIDTHxWIDTH multiply per cycle feeding a registered ACC_W accumulator.
module conv_mult_acc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 35
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [ACC_W-1:0] o_acc,
  output logic [ACC_W-1:0] o_sum
);

  logic [2*WIDTH-1:0] w_prod;
  logic [ACC_W-1:0]   w_sum;
  logic [ACC_W-1:0]   r_acc;

  assign w_prod = i_a * i_b;
  // ACC_W leaves $clog2(LEN) headroom bits, so the sum can never wrap.
  assign w_sum  = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_acc = r_acc;
  assign o_sum = w_sum;

endmodule

// File: rtl/conv_mac.sv
// Sequential dot product of one sample window with one kernel, valid/ready on both sides.
module conv_mac #(
  parameter int unsigned LEN   = conv_mac_pkg::LEN,
  parameter int unsigned WIDTH = conv_mac_pkg::WIDTH,
  parameter int unsigned ACC_W = 2 * WIDTH + $clog2(LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN*WIDTH-1:0] in_data,
  input  logic [LEN*WIDTH-1:0] in_kernel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  import conv_mac_pkg::*;

  localparam int unsigned IDX_W = $clog2(LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  mac_state_e           r_state;
  logic [LEN*WIDTH-1:0] r_win;
  logic [LEN*WIDTH-1:0] r_kern;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [ACC_W-1:0]     r_out_data;

  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [ACC_W-1:0]     w_acc;
  logic [ACC_W-1:0]     w_sum;
  logic                 w_clr;
  logic                 w_en;

  assign w_a   = r_win[r_idx*WIDTH +: WIDTH];
  assign w_b   = r_kern[r_idx*WIDTH +: WIDTH];
  // Accumulator is held at zero whenever idle so each window starts clean.
  assign w_clr = (r_state != MAC);
  assign w_en  = (r_state == MAC);

  conv_mult_acc #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mult_acc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_acc (w_acc),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_win       <= '0;
      r_kern      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_win      <= in_data;
            r_kern     <= in_kernel;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= MAC;
          end
        end
        MAC: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            // w_sum already includes the final product.
            r_out_data  <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  logic w_unused;
  assign w_unused = ^w_acc;

endmodule

// File: tb/tb_conv_mac.sv
// Directed and random scoreboard bench for conv_mac with LEN=4, WIDTH=8.
module tb_conv_mac;

  localparam int unsigned LEN   = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ACC_W = 18;

  typedef logic [LEN*WIDTH-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  vec_t             in_data = '0;
  vec_t             in_kernel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int               n_chk = 0;
  int               n_err = 0;
  int               n_out = 0;
  int               n_acc = 0;
  logic [ACC_W-1:0] last_out;
  logic [ACC_W-1:0] sb_q[$];

  conv_mac #(
    .LEN   (LEN),
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_kernel (in_kernel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic vec_t pack4(input int a, input int b, input int c, input int d);
    vec_t v;
    v[7:0]   = a[7:0];
    v[15:8]  = b[7:0];
    v[23:16] = c[7:0];
    v[31:24] = d[7:0];
    return v;
  endfunction

  function automatic logic [ACC_W-1:0] dot(input vec_t d, input vec_t k);
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] a;
    logic [ACC_W-1:0] b;
    s = '0;
    for (int i = 0; i < int'(LEN); i++) begin
      a = ACC_W'(d[i*WIDTH +: WIDTH]);
      b = ACC_W'(k[i*WIDTH +: WIDTH]);
      s = s + a * b;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, then score any handshake that the next posedge will complete.
  task automatic cycle(input logic iv, input vec_t d, input vec_t k, input logic ordy,
                       output logic accepted);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_kernel = k;
    out_ready = ordy;
    #1;
    chk("ready_valid_excl", {31'd0, in_ready && out_valid}, 32'd0);
    accepted = in_valid && in_ready;
    if (accepted) begin
      sb_q.push_back(dot(d, k));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      last_out = out_data;
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL sb_unexpected observed=%0d expected=none", out_data);
      end else begin
        chk("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
      end
    end
  endtask

  task automatic send(input vec_t d, input vec_t k, input logic ordy);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) cycle(1'b1, d, k, ordy, a);
    chk("send_accept", {31'd0, a}, 32'd1);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1, a);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic a;
    int   out0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // 1: basic sum, latency and return to ready
    cycle(1'b1, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1, a);
    chk("t1_accept", {31'd0, a}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, '0, '0, 1'b1, a);
      chk("t1_latency", {31'd0, out_valid}, {31'd0, i == 5});
      if (i == 5) chk("t1_out", 32'(out_data), 32'd10);
    end
    cycle(1'b0, '0, '0, 1'b1, a);
    chk("t1_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t1_out_valid_after", {31'd0, out_valid}, 32'd0);

    // 2: full-scale operands
    send(pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 1'b1);
    drain();
    chk("t2_out", 32'(last_out), 32'd260100);

    // 3: backpressure holds the result; in_valid pulses ignored
    send(pack4(5, 0, 7, 2), pack4(3, 9, 1, 4), 1'b0);
    for (int i = 0; i < 10 && !out_valid; i++) cycle(1'b0, '0, '0, 1'b0, a);
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'(i % 2), vec_t'($urandom), vec_t'($urandom), 1'b0, a);
      chk("t3_hold_data", 32'(out_data), 32'd30);
      chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("t3_ignored", {31'd0, a}, 32'd0);
    end
    drain();
    chk("t3_out", 32'(last_out), 32'd30);

    // 4: back-to-back windows with in_valid held high
    out0 = n_out;
    send(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b1);
    send(pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), 1'b1);
    drain();
    chk("t4_count", 32'(n_out - out0), 32'd2);
    chk("t4_last", 32'(last_out), 32'd20);

    // 5: reset two cycles into MAC aborts the window
    send(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
    cycle(1'b0, '0, '0, 1'b1, a);
    cycle(1'b0, '0, '0, 1'b1, a);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out_data", 32'(out_data), 32'd0);
    sb_q.delete();
    out0 = n_out;
    send(pack4(1, 2, 3, 4), pack4(1, 1, 1, 1), 1'b1);
    drain();
    chk("t5_count", 32'(n_out - out0), 32'd1);
    chk("t5_out", 32'(last_out), 32'd10);

    // 6: random traffic against the scoreboard
    n_acc = 0;
    out0  = n_out;
    for (int i = 0; i < 60000 && n_acc < 1000; i++) begin
      cycle(1'($urandom_range(0, 1)), vec_t'($urandom), vec_t'($urandom),
            1'($urandom_range(0, 1)), a);
    end
    drain();
    chk("t6_windows", 32'(n_acc), 32'd1000);
    chk("t6_outputs", 32'(n_out - out0), 32'd1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
